// File: rtl/mem_stage.sv
// mem_stage: memory stage of the 5-stage RV32I pipeline.
//
// Takes the EX result (effective address) and forwarded rs2 value, performs
// loads/stores over a req/gnt/rvalid data-memory interface, and holds the
// pipeline with stall_o until the access completes.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   valid_i               MEM holds a valid instruction
//   mem_read_c_i          instruction is a load
//   mem_write_c_i         instruction is a store
//   mem_size_c_i          0 byte, 1 half, 2 word (3 treated as word)
//   mem_unsigned_c_i      load zero-extends when set
//   alu_result_i          effective address / ALU result
//   store_data_i          rs2 value
//   dmem_*_o / dmem_*_i   data-memory request and response
//   mem_result_o          stage result for WB and MEM->EX forwarding
//   stall_o               freeze IF/ID/EX/MEM
//   misaligned_o          misaligned access seen; no request issued
//   dbg_state_o           current FSM state (IDLE=0, REQ=1, WAIT=2, DONE=3)
//
// Handshake: a request is live while dmem_req_o is high and its fields are
// held stable until the cycle dmem_gnt_i is sampled high; it is never
// withdrawn except by reset. Read data is accepted only in WAIT, on the
// cycle dmem_rvalid_i is high; rvalid seen in any other state is ignored.
module mem_stage #(
  parameter int DATA_W = 32,
  parameter int BE_W   = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic              mem_read_c_i,
  input  logic              mem_write_c_i,
  input  logic [1:0]        mem_size_c_i,
  input  logic              mem_unsigned_c_i,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic [DATA_W-1:0] store_data_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [DATA_W-1:0] dmem_addr_o,
  output logic [BE_W-1:0]   dmem_be_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  output logic [DATA_W-1:0] mem_result_o,
  output logic              stall_o,
  output logic              misaligned_o,
  output logic [1:0]        dbg_state_o
);

  if (DATA_W != 32) begin : g_width_check
    $error("mem_stage supports DATA_W == 32 only");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic              access;
  logic              misaligned;
  logic              start;
  logic [BE_W-1:0]   be_next;
  logic [DATA_W-1:0] wdata_next;

  logic [1:0]        size_q;
  logic              unsigned_q;
  logic [1:0]        addr_lo_q;
  logic [DATA_W-1:0] load_q;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] load_ext;

  assign access     = valid_i & (mem_read_c_i | mem_write_c_i);
  // size 3 is illegal and behaves as a word, hence the test on size[1].
  assign misaligned = access &
                      (((mem_size_c_i == 2'd1) & alu_result_i[0]) |
                       (mem_size_c_i[1] & (alu_result_i[1:0] != 2'b00)));
  assign start        = access & ~misaligned;
  assign misaligned_o = misaligned;
  assign dbg_state_o  = state_q;

  always_comb begin
    be_next    = '1;
    wdata_next = store_data_i;
    case (mem_size_c_i)
      2'd0: begin
        be_next    = 4'b0001 << alu_result_i[1:0];
        wdata_next = {4{store_data_i[7:0]}};
      end
      2'd1: begin
        be_next    = 4'b0011 << alu_result_i[1:0];
        wdata_next = {2{store_data_i[15:0]}};
      end
      default: begin
        be_next    = '1;
        wdata_next = store_data_i;
      end
    endcase
  end

  // Load alignment uses the size/sign/offset latched at request time, so it
  // does not depend on upstream holding its inputs.
  assign shifted = dmem_rdata_i >> {addr_lo_q, 3'b000};

  always_comb begin
    load_ext = dmem_rdata_i;
    case (size_q)
      2'd0: load_ext = unsigned_q ? {{(DATA_W-8){1'b0}}, shifted[7:0]}
                                  : {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
      2'd1: load_ext = unsigned_q ? {{(DATA_W-16){1'b0}}, shifted[15:0]}
                                  : {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
      default: load_ext = dmem_rdata_i;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    stall_o      = 1'b0;
    mem_result_o = alu_result_i;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_REQ;
          stall_o = 1'b1;
        end
      end
      S_REQ: begin
        stall_o = 1'b1;
        if (dmem_gnt_i) state_d = dmem_we_o ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        stall_o = 1'b1;
        if (dmem_rvalid_i) state_d = S_DONE;
      end
      S_DONE: begin
        // Pipeline advances on this edge; the access still on the inputs
        // must not be re-issued, so go straight back to IDLE.
        state_d = S_IDLE;
        if (!dmem_we_o) mem_result_o = load_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_be_o    <= '0;
      dmem_wdata_o <= '0;
      size_q       <= 2'd0;
      unsigned_q   <= 1'b0;
      addr_lo_q    <= 2'd0;
      load_q       <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start) begin
        dmem_req_o   <= 1'b1;
        dmem_we_o    <= mem_write_c_i;
        dmem_addr_o  <= {alu_result_i[DATA_W-1:2], 2'b00};
        dmem_be_o    <= be_next;
        dmem_wdata_o <= wdata_next;
        size_q       <= mem_size_c_i;
        unsigned_q   <= mem_unsigned_c_i;
        addr_lo_q    <= alu_result_i[1:0];
      end
      if (state_q == S_REQ && dmem_gnt_i) dmem_req_o <= 1'b0;
      if (state_q == S_WAIT && dmem_rvalid_i) load_q <= load_ext;
    end
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 5-stage RV32I pipeline; sits directly downstream of EX and consumes its ALU result (effective address) and forwarded rs2 data.
- Performs loads and stores to data memory over a req/gnt/rvalid handshake.
- Generates byte enables, store-data replication and load alignment/extension.
- Stalls the pipeline until the access completes, and produces the stage result for MEM->EX forwarding and for WB.

Parameters:
- DATA_W, 32, data/address width; only 32 is supported (asserted at elaboration).
- BE_W, DATA_W/8, number of byte-enable bits.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- valid_i  in  1  MEM stage holds a valid instruction.
- mem_read_c_i  in  1  instruction is a load.
- mem_write_c_i  in  1  instruction is a store; never asserted together with mem_read_c_i.
- mem_size_c_i  in  2  access size: 0 byte, 1 half, 2 word; 3 illegal, treated as word.
- mem_unsigned_c_i  in  1  load zero-extends (LBU/LHU); otherwise sign-extends.
- alu_result_i  in  DATA_W  effective address, or ALU result for non-memory instructions.
- store_data_i  in  DATA_W  rs2 value, already forwarded in EX.
- dmem_req_o  out  1  request valid.
- dmem_we_o  out  1  request is a write.
- dmem_addr_o  out  DATA_W  word-aligned address ({addr[31:2],2'b00}).
- dmem_be_o  out  BE_W  byte enables.
- dmem_wdata_o  out  DATA_W  replicated store data.
- dmem_gnt_i  in  1  request accepted this cycle.
- dmem_rvalid_i  in  1  read data valid.
- dmem_rdata_i  in  DATA_W  raw read word.
- mem_result_o  out  DATA_W  stage result for WB and MEM forwarding.
- stall_o  out  1  freeze IF/ID/EX/MEM; upstream holds MEM inputs stable while high.
- misaligned_o  out  1  misaligned access detected; no request is issued.

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE. Reset forces state IDLE; dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o and the load data register all clear to 0.
- Access definition: access = valid_i & (mem_read_c_i | mem_write_c_i).
- Misalignment: misaligned = access & ((half & addr[0]) | (word & addr[1:0]!=0)). It is combinational.
- IDLE, access and not misaligned:
  - Latch request registers: we = mem_write_c_i, word address, be, wdata, size, unsigned, addr[1:0].
  - Next state REQ. stall_o=1 this cycle (combinational).
- IDLE, misaligned: misaligned_o=1, stall_o=0, no request issued, stay in IDLE. The trap is handled elsewhere.
- IDLE, no access: stall_o=0 and mem_result_o=alu_result_i (zero added latency).
- REQ: dmem_req_o=1 with request fields held stable until dmem_gnt_i. The request is never withdrawn, and reset is the only abort.
  - gnt & write -> DONE.
  - gnt & read -> WAIT.
  - stall_o=1.
- WAIT: dmem_rvalid_i is sampled only in this state. On rvalid, capture the aligned/extended load into load_q and go to DONE. stall_o=1.
- Memory interface rule: rvalid arrives no earlier than the cycle after gnt. rvalid outside WAIT is ignored.
- DONE: stall_o=0 and mem_result_o = was_load ? load_q : alu_result_i. The pipeline advances on this edge; next state IDLE. An access still visible in DONE is not re-issued.
- Byte enables: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<addr[1:0]; word = 4'b1111.
- Store data: byte = {4{d[7:0]}}; half = {2{d[15:0]}}; word = d.
- Load extraction: shifted = rdata >> (8*addr[1:0]), then:
  - byte: sign- or zero-extend shifted[7:0].
  - half: sign- or zero-extend shifted[15:0].
  - word: rdata.
- Total latency: store is 1 (IDLE) + REQ wait + 1 (DONE) cycles; a load adds the WAIT cycles.
  - Minimum store, with gnt in the first REQ cycle: 3 cycles stalled-to-release.
  - Minimum load: 4 cycles.
- Reset mid-operation (REQ/WAIT): return to IDLE immediately, deassert dmem_req_o, drop any later rvalid.

Test Plan:
- Non-memory valid instruction, alu_result_i=0x1234 -> stall_o=0, mem_result_o=0x1234, dmem_req_o never high.
- SW addr 0x100, data 0xDEADBEEF, gnt after 2 REQ cycles -> dmem_addr_o=0x100, be=4'hF, we=1 held 2 cycles; stall released in DONE; fields stable while req high.
- SB addr 0x103, data 0x000000AB -> be=4'b1000, wdata=0xABABABAB.
- LB addr 0x201, rdata 0x0000_8000 -> mem_result_o=0xFFFFFF80. LBU, same address and data -> 0x00000080. LH addr 0x202, rdata 0x8001_0000 -> 0xFFFF8001.
- LW addr 0x102 -> misaligned_o=1, stall_o=0, no request. LH addr 0x101 -> same response.
- Assert rst_i while in WAIT -> state IDLE, dmem_req_o=0, stall_o=0; a later stray rvalid does not change mem_result_o.
